// File: rtl/stage_out_collector.sv
// stage_out_collector
//   Sits behind the 4-head attention stage. When a run starts (rising edge of
//   en while IDLE) it waits LAT cycles and then stores every o_stage word into
//   an internal register file, up to and including the word flagged by end_s.
//   It then drains the stored words in order over a valid/ready handshake and
//   pulses done once the final word has been accepted.
//
//   Optional build macro: COLLECT_RELU_EN -- negative words are stored as 0.
//
// Ports
//   clk, rstn          clock (rising edge), asynchronous active-low reset
//   en                 stage enable (a rising edge starts a run)
//   o_stage, end_s     stage result word and last-word marker
//   m_data/m_valid/m_ready/m_last   drain handshake toward the next stage
//   busy               high in WAIT, CAPTURE and DRAIN
//   done               one-cycle pulse after the last drain handshake
//   ovf                sticky: words were dropped because the buffer was full
//   n_words            words stored in the current or last run
module stage_out_collector #(
    parameter int ATT_W = 16,
    parameter int DEPTH = 64,
    parameter int LAT   = 2
) (
    input  logic                       clk,
    input  logic                       rstn,
    input  logic                       en,
    input  logic [ATT_W-1:0]           o_stage,
    input  logic                       end_s,
    output logic [ATT_W-1:0]           m_data,
    output logic                       m_valid,
    input  logic                       m_ready,
    output logic                       m_last,
    output logic                       busy,
    output logic                       done,
    output logic                       ovf,
    output logic [$clog2(DEPTH+1)-1:0] n_words
);
    localparam int NW = $clog2(DEPTH+1);
    localparam int AW = $clog2(DEPTH);
    localparam int LW = $clog2(LAT+1);

    typedef enum logic [1:0] {S_IDLE, S_WAIT, S_CAPTURE, S_DRAIN} state_e;

    state_e           state_q, state_d;
    logic             en_q;
    logic [LW-1:0]    lat_cnt_q, lat_cnt_d;
    logic [NW-1:0]    n_words_q, n_words_d;
    logic [NW-1:0]    rd_ptr_q, rd_ptr_d;
    logic             ovf_q, ovf_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;
    logic [ATT_W-1:0] mem_q [DEPTH];

    logic             start;
    logic             full;
    logic             at_last;
    logic             mem_we;
    logic [ATT_W-1:0] wdata;

    assign start   = en & ~en_q;
    assign full    = (n_words_q == NW'(DEPTH));
    assign at_last = (rd_ptr_q == n_words_q - NW'(1));

`ifdef COLLECT_RELU_EN
    assign wdata = o_stage[ATT_W-1] ? '0 : o_stage;
`else
    assign wdata = o_stage;
`endif

    // State register
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q   <= S_IDLE;
            en_q      <= 1'b0;
            lat_cnt_q <= '0;
            n_words_q <= '0;
            rd_ptr_q  <= '0;
            ovf_q     <= 1'b0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            en_q      <= en;
            lat_cnt_q <= lat_cnt_d;
            n_words_q <= n_words_d;
            rd_ptr_q  <= rd_ptr_d;
            ovf_q     <= ovf_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
        end
    end

    // The word count doubles as the write pointer: both advance together and
    // both stop once the buffer is full.
    always_ff @(posedge clk) begin
        if (mem_we) mem_q[n_words_q[AW-1:0]] <= wdata;
    end

    // Next-state logic
    always_comb begin
        state_d   = state_q;
        lat_cnt_d = lat_cnt_q;
        n_words_d = n_words_q;
        rd_ptr_d  = rd_ptr_q;
        ovf_d     = ovf_q;
        done_d    = 1'b0;
        mem_we    = 1'b0;
        unique case (state_q)
            S_IDLE: begin
                if (start) begin
                    ovf_d     = 1'b0;
                    n_words_d = '0;
                    rd_ptr_d  = '0;
                    lat_cnt_d = LW'(1);
                    // With LAT == 1 the first word already arrives in the
                    // cycle after the start cycle, so WAIT is skipped.
                    state_d   = (LAT == 1) ? S_CAPTURE : S_WAIT;
                end
            end
            S_WAIT: begin
                if (!en) begin
                    state_d = S_IDLE;
                end else begin
                    lat_cnt_d = lat_cnt_q + LW'(1);
                    // Counter reaching LAT on this edge means the next cycle
                    // (cycle LAT) carries the first valid word.
                    if (lat_cnt_q == LW'(LAT-1)) state_d = S_CAPTURE;
                end
            end
            S_CAPTURE: begin
                // end_s wins over a simultaneous en drop.
                if (en || end_s) begin
                    if (full) begin
                        ovf_d = 1'b1;
                    end else begin
                        mem_we    = 1'b1;
                        n_words_d = n_words_q + NW'(1);
                    end
                    if (end_s) begin
                        state_d  = S_DRAIN;
                        rd_ptr_d = '0;
                    end
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_DRAIN: begin
                if (m_ready) begin
                    rd_ptr_d = rd_ptr_q + NW'(1);
                    if (at_last) begin
                        state_d = S_IDLE;
                        done_d  = 1'b1;
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase
        busy_d = (state_d != S_IDLE);
    end

    // Outputs
    always_comb begin
        m_valid = (state_q == S_DRAIN);
        m_data  = m_valid ? mem_q[rd_ptr_q[AW-1:0]] : '0;
        m_last  = m_valid & at_last;
        busy    = busy_q;
        done    = done_q;
        ovf     = ovf_q;
        n_words = n_words_q;
    end
endmodule

// File: tb/tb_stage_out_collector.sv
module tb_stage_out_collector;
    logic        clk = 1'b0;
    logic        rstn, en, end_s, m_ready;
    logic [15:0] o_stage;

    logic [15:0] m_data, m_data4;
    logic        m_valid, m_last, busy, done, ovf;
    logic        m_valid4, m_last4, busy4, done4, ovf4;
    logic [6:0]  n_words;
    logic [2:0]  n_words4;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    stage_out_collector #(.ATT_W(16), .DEPTH(64), .LAT(2)) dut (
        .clk(clk), .rstn(rstn), .en(en), .o_stage(o_stage), .end_s(end_s),
        .m_data(m_data), .m_valid(m_valid), .m_ready(m_ready), .m_last(m_last),
        .busy(busy), .done(done), .ovf(ovf), .n_words(n_words)
    );

    stage_out_collector #(.ATT_W(16), .DEPTH(4), .LAT(2)) dut4 (
        .clk(clk), .rstn(rstn), .en(en), .o_stage(o_stage), .end_s(end_s),
        .m_data(m_data4), .m_valid(m_valid4), .m_ready(m_ready), .m_last(m_last4),
        .busy(busy4), .done(done4), .ovf(ovf4), .n_words(n_words4)
    );

    typedef struct {
        logic        en;
        logic [15:0] o;
        logic        es;
        logic        rdy;
        logic        v;
        logic [15:0] d;
        logic        l;
        logic        b;
        logic        dn;
    } vec_t;

    vec_t        tv[12];
    logic [15:0] got[16];
    int          got_n, last_at, done_n;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Start a run and present n words from cycle LAT=2, end_s on the last one.
    task automatic run_capture(input logic [15:0] w[8], input int n);
        en = 1'b1; o_stage = '0; end_s = 1'b0;
        tick();
        tick();
        for (int i = 0; i < n; i++) begin
            o_stage = w[i];
            end_s   = (i == n-1);
            tick();
        end
        o_stage = '0; end_s = 1'b0;
    endtask

    // Drain with m_ready held high; collects words from one of the two DUTs.
    task automatic drain(input bit sel4);
        logic v, l, dn;
        logic [15:0] d;
        got_n = 0; last_at = -1; done_n = 0;
        m_ready = 1'b1;
        for (int c = 0; c < 30; c++) begin
            @(negedge clk);
            v  = sel4 ? m_valid4 : m_valid;
            d  = sel4 ? m_data4  : m_data;
            l  = sel4 ? m_last4  : m_last;
            dn = sel4 ? done4    : done;
            if (v && got_n < 16) begin
                got[got_n] = d;
                if (l) last_at = got_n;
                got_n++;
            end
            if (dn) done_n++;
            tick();
            if (done_n > 0) break;
        end
    endtask

    initial begin
        logic [15:0] w[8];
        logic [15:0] pd;
        logic        pv, pr, pl;
        int          hs, dn;

        rstn = 1'b0; en = 1'b0; end_s = 1'b0; m_ready = 1'b1; o_stage = '0;
        #12;
        chk("rst_valid", m_valid, 0);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_ovf", ovf, 0);
        chk("rst_nwords", n_words, 0);
        chk("rst_data", m_data, 0);
        chk("rst_last", m_last, 0);
        @(negedge clk); rstn = 1'b1;
        tick(); tick();

        // ---- basic run, table driven ----
        tv[0]  = '{1'b1, 16'd0, 1'b0, 1'b1, 1'b0, 16'd0, 1'b0, 1'b0, 1'b0};
        tv[1]  = '{1'b1, 16'd0, 1'b0, 1'b1, 1'b0, 16'd0, 1'b0, 1'b1, 1'b0};
        tv[2]  = '{1'b1, 16'd1, 1'b0, 1'b1, 1'b0, 16'd0, 1'b0, 1'b1, 1'b0};
        tv[3]  = '{1'b1, 16'd2, 1'b0, 1'b1, 1'b0, 16'd0, 1'b0, 1'b1, 1'b0};
        tv[4]  = '{1'b1, 16'd3, 1'b0, 1'b1, 1'b0, 16'd0, 1'b0, 1'b1, 1'b0};
        tv[5]  = '{1'b1, 16'd4, 1'b1, 1'b1, 1'b0, 16'd0, 1'b0, 1'b1, 1'b0};
        tv[6]  = '{1'b1, 16'd0, 1'b0, 1'b1, 1'b1, 16'd1, 1'b0, 1'b1, 1'b0};
        tv[7]  = '{1'b1, 16'd0, 1'b0, 1'b1, 1'b1, 16'd2, 1'b0, 1'b1, 1'b0};
        tv[8]  = '{1'b1, 16'd0, 1'b0, 1'b1, 1'b1, 16'd3, 1'b0, 1'b1, 1'b0};
        tv[9]  = '{1'b1, 16'd0, 1'b0, 1'b1, 1'b1, 16'd4, 1'b1, 1'b1, 1'b0};
        tv[10] = '{1'b1, 16'd0, 1'b0, 1'b1, 1'b0, 16'd0, 1'b0, 1'b0, 1'b1};
        tv[11] = '{1'b1, 16'd0, 1'b0, 1'b1, 1'b0, 16'd0, 1'b0, 1'b0, 1'b0};
        for (int k = 0; k < 12; k++) begin
            en = tv[k].en; o_stage = tv[k].o; end_s = tv[k].es; m_ready = tv[k].rdy;
            @(negedge clk);
            chk($sformatf("t1_valid[%0d]", k), m_valid, tv[k].v);
            if (tv[k].v) chk($sformatf("t1_data[%0d]", k), m_data, tv[k].d);
            chk($sformatf("t1_last[%0d]", k), m_last, tv[k].l);
            chk($sformatf("t1_busy[%0d]", k), busy, tv[k].b);
            chk($sformatf("t1_done[%0d]", k), done, tv[k].dn);
            tick();
        end
        chk("t1_nwords", n_words, 4);
        chk("t1_ovf", ovf, 0);
        en = 1'b0; tick();

        // ---- back-pressure: m_ready 1,0,0,1,... ----
        w = '{16'd1, 16'd2, 16'd3, 16'd4, 16'd0, 16'd0, 16'd0, 16'd0};
        run_capture(w, 4);
        hs = 0; dn = 0; pv = 1'b0; pr = 1'b1; pd = '0; pl = 1'b0;
        for (int c = 0; c < 40; c++) begin
            m_ready = ((c % 4) == 0) || ((c % 4) == 3);
            @(negedge clk);
            if (pv && !pr) begin
                chk("bp_hold_valid", m_valid, 1);
                chk("bp_hold_data", m_data, pd);
                chk("bp_hold_last", m_last, pl);
            end
            if (m_valid && m_ready) begin
                chk("bp_data", m_data, hs + 1);
                chk("bp_last", m_last, (hs == 3));
                hs++;
            end
            if (done) dn++;
            pv = m_valid; pr = m_ready; pd = m_data; pl = m_last;
            tick();
            if (dn > 0) break;
        end
        chk("bp_handshakes", hs, 4);
        chk("bp_done", dn, 1);
        m_ready = 1'b1; en = 1'b0; tick();

        // ---- overflow on the DEPTH=4 instance ----
        w = '{16'd10, 16'd11, 16'd12, 16'd13, 16'd14, 16'd15, 16'd0, 16'd0};
        run_capture(w, 6);
        chk("ov_ovf", ovf4, 1);
        chk("ov_nwords", n_words4, 4);
        drain(1'b1);
        chk("ov_count", got_n, 4);
        for (int i = 0; i < 4 && i < got_n; i++) chk($sformatf("ov_data[%0d]", i), got[i], 10 + i);
        chk("ov_last_at", last_at, 3);
        chk("ov_done", done_n, 1);
        for (int c = 0; c < 20 && busy; c++) tick();
        chk("ov_main_idle", busy, 0);
        chk("ov_main_nwords", n_words, 6);
        chk("ov_main_ovf", ovf, 0);
        chk("ov_sticky", ovf4, 1);
        en = 1'b0; tick();

        // ---- abort after one captured word ----
        en = 1'b1; tick();
        @(negedge clk);
        chk("ab_busy_wait", busy, 1);
        chk("ab_ovf_cleared", ovf4, 0);
        chk("ab_nwords_start", n_words4, 0);
        tick();
        o_stage = 16'd7; tick();
        en = 1'b0; o_stage = '0; tick();
        for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            chk("ab_busy", busy, 0);
            chk("ab_valid", m_valid, 0);
            chk("ab_done", done, 0);
            tick();
        end
        chk("ab_nwords", n_words, 1);
        en = 1'b1; tick();
        @(negedge clk);
        chk("ab_restart_nwords", n_words, 0);
        chk("ab_restart_ovf", ovf, 0);
        chk("ab_restart_busy", busy, 1);
        en = 1'b0; tick(); tick();
        chk("ab_wait_abort", busy, 0);

        // ---- asynchronous reset mid-drain ----
        w = '{16'd20, 16'd21, 16'd22, 16'd23, 16'd0, 16'd0, 16'd0, 16'd0};
        run_capture(w, 4);
        m_ready = 1'b1;
        tick(); tick();
        #2;
        en = 1'b0; rstn = 1'b0;
        #1;
        chk("rs_valid", m_valid, 0);
        chk("rs_busy", busy, 0);
        chk("rs_nwords", n_words, 0);
        chk("rs_data", m_data, 0);
        @(negedge clk); rstn = 1'b1;
        tick();
        w = '{16'd30, 16'd31, 16'd32, 16'd0, 16'd0, 16'd0, 16'd0, 16'd0};
        run_capture(w, 3);
        drain(1'b0);
        chk("rs_count", got_n, 3);
        for (int i = 0; i < 3 && i < got_n; i++) chk($sformatf("rs_data[%0d]", i), got[i], 30 + i);
        chk("rs_last_at", last_at, 2);
        chk("rs_done", done_n, 1);
        chk("rs_nwords_after", n_words, 3);
        en = 1'b0; tick();

        // ---- negative words (ReLU when enabled) ----
        w = '{16'hFFFF, 16'h0005, 16'h8000, 16'd0, 16'd0, 16'd0, 16'd0, 16'd0};
        run_capture(w, 3);
        drain(1'b0);
        chk("rl_count", got_n, 3);
`ifdef COLLECT_RELU_EN
        chk("rl_data0", got[0], 16'h0000);
        chk("rl_data1", got[1], 16'h0005);
        chk("rl_data2", got[2], 16'h0000);
`else
        chk("rl_data0", got[0], 16'hFFFF);
        chk("rl_data1", got[1], 16'h0005);
        chk("rl_data2", got[2], 16'h8000);
`endif
        chk("rl_last_at", last_at, 2);
        en = 1'b0; tick();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
